// File: rtl/mdu_sequencer_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package mdu_sequencer_pkg;

  localparam int MDU_STEPS = 32;

  // Encodings follow funct3 of the RV32M instructions.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_type;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  function automatic logic op_is_div(mdu_op_type op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic op_is_rem(mdu_op_type op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  function automatic logic op_a_signed(mdu_op_type op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic op_b_signed(mdu_op_type op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

  // Multiplies that return the upper half of the 64-bit product.
  function automatic logic op_mul_high(mdu_op_type op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Arithmetic half of the MDU: operand magnitudes, shift-add / restoring-divide
// step, sign correction and the result register.
module mdu_datapath
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = MDU_STEPS
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            fix_wr,
  input  logic            fast_wr,
  input  mdu_op_type      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            is_fast,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  // acc_q: multiply -> {partial product, remaining multiplier bits}
  //        divide   -> {partial remainder, dividend bits / quotient bits}
  mdu_op_type        op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_mag_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   fast_val;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_part;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  // Decode incoming operands: magnitudes and the divide special cases.
  always_comb begin
    sign_a  = op_a_signed(op) & operand_a[XLEN-1];
    sign_b  = op_b_signed(op) & operand_b[XLEN-1];
    a_mag   = sign_a ? -operand_a : operand_a;
    b_mag   = sign_b ? -operand_b : operand_b;
    is_fast = op_is_div(op) &
              ((operand_b == '0) |
               (op_b_signed(op) & (operand_a == MIN_NEG) & (operand_b == ALL_ONES)));
    if (operand_b == '0)
      fast_val = op_is_rem(op) ? operand_a : ALL_ONES;
    else
      fast_val = op_is_rem(op) ? '0 : MIN_NEG;
  end

  // One iteration of shift-add and of restoring division.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_mag_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = {1'b0, div_part} - {2'b00, b_mag_q};
    div_ok   = ~div_diff[XLEN+1];
    div_rem  = div_ok ? div_diff[XLEN-1:0] : div_part[XLEN-1:0];
    div_next = {div_rem, acc_q[XLEN-2:0], div_ok};
  end

  // Sign correction and word selection for the final result.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_is_div(op_q))
      fix_val = op_is_rem(op_q) ? rem_fix : quo_fix;
    else
      fix_val = op_mul_high(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  // Operand capture on accept, then one arithmetic step per CALC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= MDU_MUL;
      acc_q   <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
    end else if (load) begin
      op_q    <= op;
      acc_q   <= {{XLEN{1'b0}}, a_mag};
      b_mag_q <= b_mag;
      neg_q   <= op_is_rem(op) ? sign_a : (sign_a ^ sign_b);
    end else if (step) begin
      acc_q   <= op_is_div(op_q) ? div_next : mul_next;
    end
  end

  // Result holds until a fast-path accept or a completed FIX overwrites it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      result_q <= '0;
    else if (fast_wr)
      result_q <= fast_val;
    else if (fix_wr)
      result_q <= fix_val;
  end

  assign result = result_q;

endmodule

// File: rtl/mdu_sequencer.sv
// Sequencing controller for the iterative multiply/divide unit: handshake
// with execute, pipeline stall, step counter and kill handling.
//
// state | meaning
// IDLE  | ready for a new operation
// CALC  | one multiply/divide step per cycle, counter runs XLEN-1 .. 0
// FIX   | sign correction, result register written
// DONE  | done pulse, result valid for the instruction leaving execute
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = MDU_STEPS
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  mdu_op_type      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int CNT_W = $clog2(XLEN);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, is_fast;
  logic             load, step, fix_wr, fast_wr;

  assign accept = (state_q == ST_IDLE) & start & ~kill;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = is_fast ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Step down-counter, loaded on accept, terminal count at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (accept)
      cnt_q <= CNT_W'(XLEN-1);
    else if ((state_q == ST_CALC) && (cnt_q != '0))
      cnt_q <= cnt_q - 1'b1;
  end

  // Handshake outputs and datapath strobes from the current state.
  always_comb begin
    ready   = (state_q == ST_IDLE);
    busy    = (state_q == ST_CALC) | (state_q == ST_FIX);
    done    = (state_q == ST_DONE);
    load    = accept;
    fast_wr = accept & is_fast;
    step    = (state_q == ST_CALC) & ~kill;
    fix_wr  = (state_q == ST_FIX) & ~kill;
  end

  assign stall = (start & ready & ~kill) | busy;

  mdu_datapath #(.XLEN(XLEN)) u_datapath (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .fix_wr    (fix_wr),
    .fast_wr   (fast_wr),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .is_fast   (is_fast),
    .result    (result)
  );

endmodule
